// File: rtl/bp_fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC generator and its branch-resolution loop.
package bp_fetch_pc_unit_pkg;

    localparam logic [31:0] BP_RESET_PC = 32'h0000_0060;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } bp_meta_t;

    typedef enum logic {
        BP_RUN,
        BP_PEND
    } bp_state_t;

endpackage

// File: rtl/bp_fetch_pc_unit_if.sv
// Signal bundle between the fetch PC unit, the BTB/BHT and the MEM-stage branch resolver.
interface bp_fetch_pc_unit_if;
    logic        if_stall;
    logic        btb_hit;
    logic        btb_prediction;
    logic        btb_is_jal;
    logic [31:0] btb_target;
    logic        MEM_br_valid;
    logic        MEM_advance;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_target;
    logic        MEM_taken;
    logic        MEM_is_jal;
    logic        MEM_pred_hit;
    logic        MEM_pred_taken;
    logic [31:0] MEM_pred_target;
    logic [31:0] IF_PC;
    logic        IF_pred_hit;
    logic        IF_pred_taken;
    logic [31:0] IF_pred_target;
    logic        flush;
    logic        btb_update;
    logic        btb_replace;
    logic        btb_branch_result;
    logic        btb_MEM_is_jal;
    logic [31:0] btb_MEM_PC;
    logic [31:0] btb_target_in;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport slave (
        input  if_stall, btb_hit, btb_prediction, btb_is_jal, btb_target,
               MEM_br_valid, MEM_advance, MEM_PC, MEM_target, MEM_taken, MEM_is_jal,
               MEM_pred_hit, MEM_pred_taken, MEM_pred_target,
        output IF_PC, IF_pred_hit, IF_pred_taken, IF_pred_target, flush,
               btb_update, btb_replace, btb_branch_result, btb_MEM_is_jal,
               btb_MEM_PC, btb_target_in, perf_branches, perf_mispredicts
    );

    modport master (
        output if_stall, btb_hit, btb_prediction, btb_is_jal, btb_target,
               MEM_br_valid, MEM_advance, MEM_PC, MEM_target, MEM_taken, MEM_is_jal,
               MEM_pred_hit, MEM_pred_taken, MEM_pred_target,
        input  IF_PC, IF_pred_hit, IF_pred_taken, IF_pred_target, flush,
               btb_update, btb_replace, btb_branch_result, btb_MEM_is_jal,
               btb_MEM_PC, btb_target_in, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/bp_fetch_pc_unit_perf_counters.sv
// Saturating branch / mispredict event counters for the fetch PC unit.
module bp_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_branch,
    input  logic        inc_mis,
    output logic [31:0] branches,
    output logic [31:0] mispredicts
);
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (inc_branch && branches_q != 32'hFFFF_FFFF) branches_d = branches_q + 32'd1;
        if (inc_mis && mispredicts_q != 32'hFFFF_FFFF) mispredicts_d = mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= 32'd0;
            mispredicts_q <= 32'd0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign branches    = branches_q;
    assign mispredicts = mispredicts_q;
endmodule

// File: rtl/bp_fetch_pc_unit.sv
// Fetch PC generator: BTB-driven next-PC select, MEM-stage mispredict redirect, BTB write port.
// Optional perf counters are built only when BP_PERF_COUNTERS_EN is defined.
module bp_fetch_pc_unit
    import bp_fetch_pc_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    bp_fetch_pc_unit_if.slave bus
);
    bp_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        wr_update_q, wr_update_d;
    logic        wr_replace_q, wr_replace_d;
    logic        wr_result_q, wr_result_d;
    logic        wr_is_jal_q, wr_is_jal_d;
    logic [31:0] wr_pc_q, wr_pc_d;
    logic [31:0] wr_target_q, wr_target_d;
    logic        pt, res, mis;
    logic [31:0] fix_pc, pc_plus4;
    bp_meta_t    if_meta;

    always_comb begin
        pt       = bus.btb_hit && (bus.btb_prediction || bus.btb_is_jal);
        pc_plus4 = pc_q + 32'd4;
        res      = bus.MEM_br_valid && bus.MEM_advance;
        mis      = res && ((bus.MEM_taken != bus.MEM_pred_taken) ||
                           (bus.MEM_taken && bus.MEM_target != bus.MEM_pred_target));
        fix_pc   = bus.MEM_taken ? bus.MEM_target : bus.MEM_PC + 32'd4;
        if_meta.hit    = bus.btb_hit;
        if_meta.taken  = pt;
        if_meta.target = pt ? bus.btb_target : pc_plus4;
    end

    // A redirect that arrives during a stall is parked in pend_pc; a later one replaces it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            BP_RUN: begin
                if (mis) begin
                    if (bus.if_stall) begin
                        pend_pc_d = fix_pc;
                        state_d   = BP_PEND;
                    end else begin
                        pc_d = fix_pc;
                    end
                end else if (!bus.if_stall) begin
                    pc_d = pt ? bus.btb_target : pc_plus4;
                end
            end
            BP_PEND: begin
                if (mis) pend_pc_d = fix_pc;
                if (!bus.if_stall) begin
                    pc_d    = mis ? fix_pc : pend_pc_q;
                    state_d = BP_RUN;
                end
            end
            default: state_d = BP_RUN;
        endcase
    end

    always_comb begin
        wr_update_d  = res && bus.MEM_pred_hit;
        wr_replace_d = res && !bus.MEM_pred_hit && bus.MEM_taken;
        wr_result_d  = res && bus.MEM_taken;
        wr_is_jal_d  = res && bus.MEM_is_jal;
        wr_pc_d      = res ? bus.MEM_PC : wr_pc_q;
        wr_target_d  = res ? bus.MEM_target : wr_target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BP_RUN;
            pc_q         <= BP_RESET_PC;
            pend_pc_q    <= 32'd0;
            wr_update_q  <= 1'b0;
            wr_replace_q <= 1'b0;
            wr_result_q  <= 1'b0;
            wr_is_jal_q  <= 1'b0;
            wr_pc_q      <= 32'd0;
            wr_target_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            wr_update_q  <= wr_update_d;
            wr_replace_q <= wr_replace_d;
            wr_result_q  <= wr_result_d;
            wr_is_jal_q  <= wr_is_jal_d;
            wr_pc_q      <= wr_pc_d;
            wr_target_q  <= wr_target_d;
        end
    end

    assign bus.IF_PC             = pc_q;
    assign bus.IF_pred_hit       = if_meta.hit;
    assign bus.IF_pred_taken     = if_meta.taken;
    assign bus.IF_pred_target    = if_meta.target;
    assign bus.flush             = mis;
    assign bus.btb_update        = wr_update_q;
    assign bus.btb_replace       = wr_replace_q;
    assign bus.btb_branch_result = wr_result_q;
    assign bus.btb_MEM_is_jal    = wr_is_jal_q;
    assign bus.btb_MEM_PC        = wr_pc_q;
    assign bus.btb_target_in     = wr_target_q;

`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] perf_br, perf_mis;

    bp_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .inc_branch  (res),
        .inc_mis     (mis),
        .branches    (perf_br),
        .mispredicts (perf_mis)
    );

    assign bus.perf_branches    = perf_br;
    assign bus.perf_mispredicts = perf_mis;
`else
    assign bus.perf_branches    = 32'd0;
    assign bus.perf_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_bp_fetch_pc_unit.sv
// Bench for bp_fetch_pc_unit: vector table for next-PC/redirect, hand sequences for stall/PEND/reset.
module tb_bp_fetch_pc_unit;
    import bp_fetch_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_fetch_pc_unit_if bus();

    bp_fetch_pc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        stall;
        logic        hit;
        logic        pred;
        logic        jal;
        logic [31:0] tgt;
        logic        brv;
        logic        adv;
        logic [31:0] mpc;
        logic [31:0] mtgt;
        logic        taken;
        logic        isjal;
        logic        phit;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        exp_flush;
        logic        exp_pt;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic        upd;
        logic        repl;
        logic        result;
        logic        jal;
        logic [31:0] pc;
        logic [31:0] tgt;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          upd_seen = 0;
    logic [31:0] exp_pc;
    logic [31:0] m_br = 0;
    logic [31:0] m_mis = 0;
    wr_t         wr_q[$];
    vec_t        vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.if_stall        = 1'b0;
        bus.btb_hit         = 1'b0;
        bus.btb_prediction  = 1'b0;
        bus.btb_is_jal      = 1'b0;
        bus.btb_target      = 32'd0;
        bus.MEM_br_valid    = 1'b0;
        bus.MEM_advance     = 1'b0;
        bus.MEM_PC          = 32'd0;
        bus.MEM_target      = 32'd0;
        bus.MEM_taken       = 1'b0;
        bus.MEM_is_jal      = 1'b0;
        bus.MEM_pred_hit    = 1'b0;
        bus.MEM_pred_taken  = 1'b0;
        bus.MEM_pred_target = 32'd0;
    endtask

    task automatic mem_br(input logic adv, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken, input logic phit, input logic ptaken,
                          input logic [31:0] ptgt);
        bus.MEM_br_valid    = 1'b1;
        bus.MEM_advance     = adv;
        bus.MEM_PC          = pc;
        bus.MEM_target      = tgt;
        bus.MEM_taken       = taken;
        bus.MEM_is_jal      = 1'b0;
        bus.MEM_pred_hit    = phit;
        bus.MEM_pred_taken  = ptaken;
        bus.MEM_pred_target = ptgt;
    endtask

    task automatic check_wr(input string tag);
        wr_t w;
        if (bus.btb_update === 1'b1) upd_seen++;
        if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk({tag, " btb_update"}, {31'd0, bus.btb_update}, {31'd0, w.upd});
            chk({tag, " btb_replace"}, {31'd0, bus.btb_replace}, {31'd0, w.repl});
            chk({tag, " btb_result"}, {31'd0, bus.btb_branch_result}, {31'd0, w.result});
            chk({tag, " btb_is_jal"}, {31'd0, bus.btb_MEM_is_jal}, {31'd0, w.jal});
            chk({tag, " btb_MEM_PC"}, bus.btb_MEM_PC, w.pc);
            chk({tag, " btb_target_in"}, bus.btb_target_in, w.tgt);
        end else begin
            chk({tag, " idle btb_update"}, {31'd0, bus.btb_update}, 32'd0);
            chk({tag, " idle btb_replace"}, {31'd0, bus.btb_replace}, 32'd0);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef BP_PERF_COUNTERS_EN
        chk({tag, " perf_branches"}, bus.perf_branches, m_br);
        chk({tag, " perf_mispredicts"}, bus.perf_mispredicts, m_mis);
`else
        chk({tag, " perf_branches"}, bus.perf_branches, 32'd0);
        chk({tag, " perf_mispredicts"}, bus.perf_mispredicts, 32'd0);
`endif
    endtask

    // Inputs are already driven; check flush, record the expected BTB write, clock, check results.
    task automatic cycle(input string tag, input logic exp_flush, input logic [31:0] exp_next);
        wr_t w;
        #1;
        chk({tag, " flush"}, {31'd0, bus.flush}, {31'd0, exp_flush});
        if (bus.MEM_br_valid && bus.MEM_advance) begin
            w.upd    = bus.MEM_pred_hit;
            w.repl   = !bus.MEM_pred_hit && bus.MEM_taken;
            w.result = bus.MEM_taken;
            w.jal    = bus.MEM_is_jal;
            w.pc     = bus.MEM_PC;
            w.tgt    = bus.MEM_target;
            wr_q.push_back(w);
            m_br = m_br + 32'd1;
            if (exp_flush) m_mis = m_mis + 32'd1;
        end
        @(posedge clk);
        #1;
        chk({tag, " IF_PC"}, bus.IF_PC, exp_next);
        exp_pc = exp_next;
        check_wr(tag);
        check_perf(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          stall hit pred jal tgt            brv adv mpc            mtgt           tk jal ph pt ptgt           fl pt next
        vecs[0]  = '{0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h64};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h68};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h6C};
        vecs[3]  = '{0, 1, 1, 0, 32'h80,         0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 32'h80};
        vecs[4]  = '{0, 1, 0, 1, 32'h200,        0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 32'h200};
        vecs[5]  = '{0, 1, 0, 0, 32'h300,        0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h204};
        vecs[6]  = '{0, 1, 1, 0, 32'h500,        1, 1, 32'h100,        32'h180,      1, 0, 0, 0, 32'h0,   1, 1, 32'h180};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h180,        32'h1C0,      1, 0, 1, 1, 32'h1C0, 0, 0, 32'h184};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h40,         32'h90,       1, 0, 1, 1, 32'h94,  1, 0, 32'h90};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h88,         32'h10,       0, 0, 1, 1, 32'h10,  1, 0, 32'h8C};
        vecs[10] = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h300,        32'h10,       0, 0, 1, 0, 32'h999, 0, 0, 32'h90};
        vecs[11] = '{1, 1, 1, 0, 32'h500,        0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 32'h90};
        vecs[12] = '{0, 1, 1, 0, 32'hFFFF_FFFC,  0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 32'hFFFF_FFFC};
        vecs[13] = '{0, 0, 0, 0, 32'h0,          0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 32'h0};
        vecs[14] = '{0, 0, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'h10,       0, 0, 1, 1, 32'h10,  1, 0, 32'h0};
        vecs[15] = '{0, 0, 0, 0, 32'h0,          1, 1, 32'h20,         32'h400,      1, 1, 0, 0, 32'h0,   1, 0, 32'h400};
        vecs[16] = '{0, 0, 0, 0, 32'h0,          1, 0, 32'h500,        32'h600,      1, 0, 0, 0, 32'h0,   0, 0, 32'h404};

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset IF_PC", bus.IF_PC, 32'h60);
        chk("reset flush", {31'd0, bus.flush}, 32'd0);
        chk("reset btb_MEM_PC", bus.btb_MEM_PC, 32'd0);
        chk("reset btb_target_in", bus.btb_target_in, 32'd0);
        chk("reset state", {31'd0, dut.state_q}, {31'd0, BP_RUN});
        check_wr("reset");
        check_perf("reset");
        rst = 1'b0;
        exp_pc = 32'h60;

        for (int i = 0; i < 17; i++) begin
            bus.if_stall        = vecs[i].stall;
            bus.btb_hit         = vecs[i].hit;
            bus.btb_prediction  = vecs[i].pred;
            bus.btb_is_jal      = vecs[i].jal;
            bus.btb_target      = vecs[i].tgt;
            bus.MEM_br_valid    = vecs[i].brv;
            bus.MEM_advance     = vecs[i].adv;
            bus.MEM_PC          = vecs[i].mpc;
            bus.MEM_target      = vecs[i].mtgt;
            bus.MEM_taken       = vecs[i].taken;
            bus.MEM_is_jal      = vecs[i].isjal;
            bus.MEM_pred_hit    = vecs[i].phit;
            bus.MEM_pred_taken  = vecs[i].ptaken;
            bus.MEM_pred_target = vecs[i].ptgt;
            #1;
            chk($sformatf("vec%0d IF_pred_hit", i), {31'd0, bus.IF_pred_hit}, {31'd0, vecs[i].hit});
            chk($sformatf("vec%0d IF_pred_taken", i), {31'd0, bus.IF_pred_taken}, {31'd0, vecs[i].exp_pt});
            chk($sformatf("vec%0d IF_pred_target", i), bus.IF_pred_target,
                vecs[i].exp_pt ? vecs[i].tgt : exp_pc + 32'd4);
            cycle($sformatf("vec%0d", i), vecs[i].exp_flush, vecs[i].exp_pc);
        end

        // Mispredict under a 4-cycle stall: redirect parks, BTB prediction ignored in PEND.
        idle();
        bus.if_stall = 1'b1;
        mem_br(1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("stall_mis", 1'b1, 32'h404);
        chk("stall_mis state", {31'd0, dut.state_q}, {31'd0, BP_PEND});
        idle();
        bus.if_stall       = 1'b1;
        bus.btb_hit        = 1'b1;
        bus.btb_prediction = 1'b1;
        bus.btb_target     = 32'h700;
        for (int i = 0; i < 3; i++) cycle($sformatf("pend_hold%0d", i), 1'b0, 32'h404);
        bus.if_stall = 1'b0;
        cycle("pend_release", 1'b0, 32'h180);
        chk("pend_release state", {31'd0, dut.state_q}, {31'd0, BP_RUN});
        idle();
        cycle("after_pend", 1'b0, 32'h184);

        // Branch held in MEM for 3 cycles, then retires with a correct prediction.
        upd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            mem_br(1'b0, 32'h240, 32'h260, 1'b1, 1'b1, 1'b1, 32'h260);
            cycle($sformatf("held%0d", i), 1'b0, exp_pc + 32'd4);
        end
        mem_br(1'b1, 32'h240, 32'h260, 1'b1, 1'b1, 1'b1, 32'h260);
        cycle("held_retire", 1'b0, exp_pc + 32'd4);
        idle();
        cycle("held_after", 1'b0, exp_pc + 32'd4);
        chk("held update_count", upd_seen, 1);

        // Second mispredict during PEND overrides the first.
        bus.if_stall = 1'b1;
        mem_br(1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("ovr_first", 1'b1, 32'h198);
        mem_br(1'b1, 32'h200, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10);
        cycle("ovr_second", 1'b1, 32'h198);
        idle();
        cycle("ovr_release", 1'b0, 32'h204);
        cycle("ovr_after", 1'b0, 32'h208);

        // Reset while a redirect is pending discards it.
        bus.if_stall = 1'b1;
        mem_br(1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("rst_mis", 1'b1, 32'h208);
        idle();
        bus.if_stall = 1'b1;
        rst = 1'b1;
        m_br  = 32'd0;
        m_mis = 32'd0;
        cycle("rst_pend", 1'b0, 32'h60);
        chk("rst_pend state", {31'd0, dut.state_q}, {31'd0, BP_RUN});
        rst = 1'b0;
        bus.if_stall = 1'b0;
        cycle("rst_after", 1'b0, 32'h64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
